key_schedule_gen: RTL and testbench



---
 rtl/crypto_pkg.sv | 29 ++
 rtl/key_round_fn.sv | 21 ++
 rtl/key_schedule_gen.sv | 158 +++++++++++++++
 tb/tb_key_schedule_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/crypto_pkg.sv
// Shared definitions for the crypto core key path: default key width, key schedule
// FSM encoding and the reference round-key function (rotate-left, XOR round constant).
package crypto_pkg;

    localparam int unsigned KEY_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StReq  = 3'd1,
        StCapt = 3'd2,
        StEmit = 3'd3,
        StFin  = 3'd4,
        StGen  = 3'd5
    } ks_state_e;

    // Next round key at the default width: rotl(rk, rot) ^ zero-extended (idx + 1).
    function automatic logic [KEY_W_DEFAULT-1:0] round_key_next(
        input logic [KEY_W_DEFAULT-1:0] rk,
        input logic [3:0]               idx,
        input int unsigned              rot
    );
        logic [KEY_W_DEFAULT-1:0] rotated;
        logic [3:0]               rc;
        rotated = (rk << rot) | (rk >> (KEY_W_DEFAULT - rot));
        rc      = idx + 4'd1;
        return rotated ^ {{(KEY_W_DEFAULT-4){1'b0}}, rc};
    endfunction

endpackage

// File: rtl/key_round_fn.sv
// Combinational round function: next key = rotl(rk, ROT) ^ zero-extended (idx + 1).
module key_round_fn
    import crypto_pkg::*;
#(
    parameter int unsigned KEY_W = KEY_W_DEFAULT,
    parameter int unsigned ROT   = 3
) (
    input  logic [KEY_W-1:0] i_rk,
    input  logic [3:0]       i_idx,
    output logic [KEY_W-1:0] o_rk
);

    logic [3:0]       w_rc;
    logic [KEY_W-1:0] w_rot;

    // Round constant is 4-bit; no wrap occurs because idx never exceeds 14 here.
    assign w_rc  = i_idx + 4'd1;
    assign w_rot = (i_rk << ROT) | (i_rk >> (KEY_W - ROT));
    assign o_rk  = w_rot ^ {{(KEY_W-4){1'b0}}, w_rc};

endmodule

// File: rtl/key_schedule_gen.sv
// Key schedule generator: fetches the stored key, expands it into ROUNDS round keys and
// streams them out over valid/ready. Optional macro KEY_SCHEDULE_DECRYPT_EN adds a dec
// input that pre-computes all keys into a buffer and emits them in reverse order.
module key_schedule_gen
    import crypto_pkg::*;
#(
    parameter int unsigned KEY_W  = KEY_W_DEFAULT,
    parameter int unsigned ROUNDS = 8,
    parameter int unsigned ROT    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef KEY_SCHEDULE_DECRYPT_EN
    input  logic             dec,
`endif
    output logic             key_req,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] rk_out,
    output logic [3:0]       rk_idx,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

    ks_state_e        r_state;
    ks_state_e        w_next;
    logic [KEY_W-1:0] r_rk;
    logic [3:0]       r_cnt;
    logic [KEY_W-1:0] w_rk_next;
    logic [3:0]       w_cnt_inc;
    logic             w_last;

`ifdef KEY_SCHEDULE_DECRYPT_EN
    localparam int unsigned IDX_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    logic             r_dec;
    logic [KEY_W-1:0] r_buf [0:ROUNDS-1];
    logic [3:0]       w_cnt_dec;
    assign w_cnt_dec = r_cnt - 4'd1;
`endif

    assign w_cnt_inc = r_cnt + 4'd1;
    assign w_last    = (r_cnt == LAST_IDX);

    // One round-function instance serves both the on-the-fly path and GEN.
    key_round_fn #(
        .KEY_W (KEY_W),
        .ROT   (ROT)
    ) u_round_fn (
        .i_rk  (r_rk),
        .i_idx (r_cnt),
        .o_rk  (w_rk_next)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            StIdle: if (start) w_next = StReq;
            StReq:  w_next = StCapt;
`ifdef KEY_SCHEDULE_DECRYPT_EN
            StCapt: w_next = r_dec ? StGen : StEmit;
            StGen:  if (w_last) w_next = StEmit;
            StEmit: begin
                if (rk_ready) begin
                    if (r_dec ? (r_cnt == 4'd0) : w_last) w_next = StFin;
                end
            end
`else
            StCapt: w_next = StEmit;
            StEmit: if (rk_ready && w_last) w_next = StFin;
`endif
            StFin:  w_next = StIdle;
            default: w_next = StIdle;
        endcase
    end

    // Moore outputs; key/index are forced to zero whenever they are not being presented.
    always_comb begin
        key_req  = (r_state == StReq);
        rk_valid = (r_state == StEmit);
        busy     = (r_state != StIdle);
        done     = (r_state == StFin);
        rk_out   = rk_valid ? r_rk : '0;
        rk_idx   = rk_valid ? r_cnt : 4'd0;
    end

    // Key register, round counter and (optionally) the decrypt key buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rk  <= '0;
            r_cnt <= 4'd0;
`ifdef KEY_SCHEDULE_DECRYPT_EN
            r_dec <= 1'b0;
            for (int k = 0; k < int'(ROUNDS); k++) begin
                r_buf[k] <= '0;
            end
`endif
        end else begin
            case (r_state)
`ifdef KEY_SCHEDULE_DECRYPT_EN
                StIdle: if (start) r_dec <= dec;
`endif
                StCapt: begin
                    r_rk  <= key_in;
                    r_cnt <= 4'd0;
`ifdef KEY_SCHEDULE_DECRYPT_EN
                    r_buf[0] <= key_in;
`endif
                end
`ifdef KEY_SCHEDULE_DECRYPT_EN
                // Last GEN cycle leaves r_rk = rk[ROUNDS-1] and r_cnt = ROUNDS-1 for EMIT.
                StGen: begin
                    if (!w_last) begin
                        r_rk                         <= w_rk_next;
                        r_buf[w_cnt_inc[IDX_W-1:0]] <= w_rk_next;
                        r_cnt                        <= w_cnt_inc;
                    end
                end
`endif
                StEmit: begin
                    if (rk_ready) begin
`ifdef KEY_SCHEDULE_DECRYPT_EN
                        if (r_dec) begin
                            if (r_cnt != 4'd0) begin
                                r_rk  <= r_buf[w_cnt_dec[IDX_W-1:0]];
                                r_cnt <= w_cnt_dec;
                            end
                        end else if (!w_last) begin
                            r_rk  <= w_rk_next;
                            r_cnt <= w_cnt_inc;
                        end
`else
                        if (!w_last) begin
                            r_rk  <= w_rk_next;
                            r_cnt <= w_cnt_inc;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_schedule_gen.sv
// Directed testbench for key_schedule_gen with hand-computed round keys for key 16'h1234.
module tb_key_schedule_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        key_req;
    logic [15:0] key_in;
    logic [15:0] rk_out;
    logic [3:0]  rk_idx;
    logic        rk_valid;
    logic        rk_ready;
    logic        busy;
    logic        done;
`ifdef KEY_SCHEDULE_DECRYPT_EN
    logic        dec;
`endif

    int n_vec  = 0;
    int n_bad  = 0;
    int n_req  = 0;
    int n_done = 0;

    // rk[i+1] = rotl(rk[i],3) ^ (i+1), worked by hand from 16'h1234.
    logic [15:0] exp_tbl [0:7] = '{16'h1234, 16'h91A1, 16'h8D0E, 16'h6877,
                                   16'h43BF, 16'h1DFF, 16'hEFFE, 16'h7FF0};

    key_schedule_gen #(
        .KEY_W  (16),
        .ROUNDS (8),
        .ROT    (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef KEY_SCHEDULE_DECRYPT_EN
        .dec      (dec),
`endif
        .key_req  (key_req),
        .key_in   (key_in),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (key_req) n_req++;
        if (done)    n_done++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Ascending run of key 16'h1234 with optional stall, start-while-busy and key_in glitches.
    task automatic run_asc(input int stall_at, input int stall_n, input int restart_at,
                           input bit glitch);
        int req0;
        int done0;
        req0   = n_req;
        done0  = n_done;
        start  = 1'b1;
        key_in = glitch ? 16'hFFFF : 16'h1234;
        tick;                                   // REQ
        start = 1'b0;
        check_eq("req_strobe", key_req, 1'b1);
        check_eq("req_valid", rk_valid, 1'b0);
        tick;                                   // CAPT
        check_eq("capt_req", key_req, 1'b0);
        check_eq("capt_busy", busy, 1'b1);
        check_eq("capt_valid", rk_valid, 1'b0);
        key_in = 16'h1234;
        tick;                                   // EMIT idx 0
        if (glitch) key_in = 16'hBEEF;
        for (int idx = 0; idx < 8; idx++) begin
            if (idx == stall_at) begin
                rk_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    check_eq("stall_valid", rk_valid, 1'b1);
                    check_eq("stall_idx", rk_idx, idx);
                    check_eq("stall_key", rk_out, exp_tbl[idx]);
                    tick;
                end
                rk_ready = 1'b1;
            end
            check_eq("emit_valid", rk_valid, 1'b1);
            check_eq("emit_idx", rk_idx, idx);
            check_eq("emit_key", rk_out, exp_tbl[idx]);
            check_eq("emit_done", done, 1'b0);
            if (idx == restart_at) start = 1'b1;
            if (glitch) key_in = 16'h0F0F ^ 16'(idx);
            tick;
            start = 1'b0;
        end
        check_eq("fin_done", done, 1'b1);
        check_eq("fin_valid", rk_valid, 1'b0);
        tick;
        check_eq("idle_done", done, 1'b0);
        check_eq("idle_busy", busy, 1'b0);
        check_eq("run_req_count", n_req - req0, 1);
        check_eq("run_done_count", n_done - done0, 1);
    endtask

    initial begin
        int done0;
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        rk_ready = 1'b1;
        key_in   = 16'h0000;
`ifdef KEY_SCHEDULE_DECRYPT_EN
        dec      = 1'b0;
`endif
        #1;
        check_eq("rst_outs", {key_req, rk_valid, busy, done, rk_idx, rk_out}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick;
        check_eq("post_rst_busy", busy, 1'b0);

        run_asc(-1, 0, -1, 1'b0);               // basic
        run_asc(3, 5, -1, 1'b0);                // backpressure at idx 3
        run_asc(-1, 0, 2, 1'b0);                // start while busy at idx 2
        run_asc(-1, 0, -1, 1'b1);               // key_in glitches

        // Reset at idx 4.
        start  = 1'b1;
        key_in = 16'h1234;
        tick;
        start = 1'b0;
        tick;
        tick;
        repeat (4) tick;
        check_eq("pre_rst_idx", rk_idx, 4);
        done0 = n_done;
        rst   = 1'b1;
        #1;
        check_eq("mid_rst_outs", {key_req, rk_valid, busy, done, rk_idx, rk_out}, 0);
        tick;
        rst = 1'b0;
        tick;
        check_eq("mid_rst_no_done", n_done - done0, 0);
        check_eq("mid_rst_busy", busy, 1'b0);

        start  = 1'b1;
        key_in = 16'h0001;
        tick;
        start = 1'b0;
        tick;
        tick;
        check_eq("rerun_idx0", rk_idx, 0);
        check_eq("rerun_key0", rk_out, 16'h0001);
        tick;
        check_eq("rerun_idx1", rk_idx, 1);
        check_eq("rerun_key1", rk_out, 16'h0009);
        n = 0;
        while (!done && n < 20) begin
            tick;
            n++;
        end
        check_eq("rerun_done", done, 1'b1);
        tick;

`ifdef KEY_SCHEDULE_DECRYPT_EN
        // Decrypt order: pre-compute then emit idx 7..0.
        dec    = 1'b1;
        start  = 1'b1;
        key_in = 16'h1234;
        tick;
        start = 1'b0;
        dec   = 1'b0;
        tick;
        tick;
        n = 0;
        while (!rk_valid && n < 30) begin
            tick;
            n++;
        end
        check_eq("dec_gap", n, 8);
        for (int idx = 7; idx >= 0; idx--) begin
            check_eq("dec_idx", rk_idx, idx);
            check_eq("dec_key", rk_out, exp_tbl[idx]);
            check_eq("dec_done", done, 1'b0);
            tick;
        end
        check_eq("dec_fin_done", done, 1'b1);
        tick;
        check_eq("dec_idle", busy, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
